// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: key code constant,
// debounce FSM states, frame classes and the row/column to board-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } dbn_state_t;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_SINGLE = 2'd1,
        FC_OTHER  = 2'd2
    } frame_class_t;

    // Row 3 and column 3 are non-board keys and map to KEY_NONE.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row != 2'd3 && col != 2'd3) begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col};
        end else begin
            code = KEY_NONE;
        end
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a press after DEBOUNCE_FRAMES identical
// single-key frames and re-arms only after DEBOUNCE_FRAMES empty frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_strobe,
    input  frame_class_t frame_class,
    input  logic [3:0]   frame_code,
    output logic         emit,
    output logic         held,
    output logic [3:0]   cand
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
    localparam bit ONE_FRAME = (DEBOUNCE_FRAMES <= 1);

    dbn_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    cand_nx;
    logic          emit_nx;

    // Next-state logic; the counter never exceeds DEBOUNCE_FRAMES, so it cannot wrap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        emit_nx  = 1'b0;
        if (frame_strobe) begin
            case (state)
                ST_IDLE: begin
                    if (frame_class == FC_SINGLE) begin
                        cand_nx = frame_code;
                        cnt_nx  = CNT_ONE;
                        if (ONE_FRAME) begin
                            emit_nx  = 1'b1;
                            state_nx = ST_HELD;
                        end else begin
                            state_nx = ST_PRESS_CHK;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_PRESS_CHK: begin
                    if (frame_class == FC_SINGLE && frame_code == cand) begin
                        cnt_nx = cnt + CNT_ONE;
                        if (cnt >= CNT_LAST) begin
                            emit_nx  = 1'b1;
                            state_nx = ST_HELD;
                        end else begin
                            state_nx = ST_PRESS_CHK;
                        end
                    end else if (frame_class == FC_SINGLE) begin
                        cand_nx = frame_code;
                        cnt_nx  = CNT_ONE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (frame_class == FC_NONE) begin
                        cnt_nx   = CNT_ONE;
                        state_nx = ONE_FRAME ? ST_IDLE : ST_REL_CHK;
                    end else begin
                        state_nx = ST_HELD;
                    end
                end
                ST_REL_CHK: begin
                    if (frame_class == FC_NONE) begin
                        cnt_nx   = cnt + CNT_ONE;
                        state_nx = (cnt >= CNT_LAST) ? ST_IDLE : ST_REL_CHK;
                    end else begin
                        state_nx = ST_HELD;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else begin
            state_nx = state;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= KEY_NONE;
            emit  <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cand  <= cand_nx;
            emit  <= emit_nx;
            held  <= (state_nx == ST_HELD) || (state_nx == ST_REL_CHK);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, frame accumulator.
// Define KEYPAD_LEVEL_OUT_EN to hold keyValid/keyPadBuf while the key is down.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DWELL      = 3,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypadRow,
    output logic [3:0] keypadCol,
    output logic [3:0] keyPadBuf,
    output logic       keyValid
);

    localparam int DW = $clog2(SCAN_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

    logic [DW-1:0] dwell_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [11:0]   acc;
    logic [15:0]   frame_bits;
    logic          last_dwell;
    logic          frame_strobe;
    logic [1:0]    hits;
    logic [3:0]    found;
    frame_class_t  frame_class;
    logic          emit;
    logic          held;
    logic [3:0]    cand;

    assign last_dwell   = (dwell_cnt == DWELL_LAST);
    assign frame_strobe = last_dwell && (col_idx == 2'd3);

    // Column scan: dwell counter and registered one-hot-low column drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            keypadCol <= 4'b1110;
        end else if (last_dwell) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
            keypadCol <= col_drive(col_idx + 2'd1);
        end else begin
            dwell_cnt <= dwell_cnt + DWELL_ONE;
        end
    end

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= keypadRow;
            row_sync <= row_meta;
        end
    end

    // Frame accumulator; column 3 is consumed directly at the frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 12'd0;
        end else if (last_dwell) begin
            case (col_idx)
                2'd0:    acc[3:0]  <= ~row_sync;
                2'd1:    acc[7:4]  <= ~row_sync;
                2'd2:    acc[11:8] <= ~row_sync;
                default: acc       <= 12'd0;
            endcase
        end else begin
            acc <= acc;
        end
    end

    assign frame_bits = {~row_sync, acc};

    // Frame classification: key count (saturating at 2) and code of the last key seen.
    always_comb begin
        hits  = 2'd0;
        found = KEY_NONE;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                found = frame_bits[4*c + r] ? key_code(2'(r), 2'(c)) : found;
                hits  = (frame_bits[4*c + r] && hits != 2'd2) ? hits + 2'd1 : hits;
            end
        end
        if (hits == 2'd0) begin
            frame_class = FC_NONE;
        end else if (hits == 2'd1 && found != KEY_NONE) begin
            frame_class = FC_SINGLE;
        end else begin
            frame_class = FC_OTHER;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_strobe (frame_strobe),
        .frame_class  (frame_class),
        .frame_code   (found),
        .emit         (emit),
        .held         (held),
        .cand         (cand)
    );

`ifdef KEYPAD_LEVEL_OUT_EN
    // emit only fires on entry to HELD, so it is already covered by held.
    assign keyValid  = held | emit;
    assign keyPadBuf = held ? cand : KEY_NONE;
`else
    assign keyValid  = emit;
    assign keyPadBuf = (emit && held) ? cand : KEY_NONE;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and a
// frame-level reference model feeding an expected-code scoreboard.
module tb_keypad_scanner;

    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keypadRow;
    logic [3:0] keypadCol;
    logic [3:0] keyPadBuf;
    logic       keyValid;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;
    int m_state, m_cnt, m_cand;
    bit m_held;
    int exp_q[$];

    keypad_scanner #(.SCAN_DWELL(3), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .rst       (rst),
        .keypadRow (keypadRow),
        .keypadCol (keypadCol),
        .keyPadBuf (keyPadBuf),
        .keyValid  (keyValid)
    );

    always #5 clk = ~clk;

    // Membrane matrix: a pressed key pulls its row low when its column is driven low.
    always_comb begin
        keypadRow = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keypadCol[c] == 1'b0 && keys[c*4 + r]) keypadRow[r] = 1'b0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] kb(input int r, input int c);
        logic [15:0] v;
        v = 16'd0;
        v[c*4 + r] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_cand = 15; m_held = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_frame(input logic [15:0] m, output bit emit);
        int n, p, k, cls;
        n = 0; p = 0;
        for (int b = 0; b < 16; b++) if (m[b]) begin n++; p = b; end
        k = ((p % 4) < 3 && (p / 4) < 3) ? (p % 4) * 3 + (p / 4) : 15;
        cls = (n == 0) ? 0 : ((n == 1 && k != 15) ? 1 : 2);
        emit = 1'b0;
        case (m_state)
            0: if (cls == 1) begin
                   m_cand = k; m_cnt = 1;
                   if (m_cnt >= DF) begin emit = 1'b1; m_state = 2; end else m_state = 1;
               end
            1: if (cls == 1 && k == m_cand) begin
                   m_cnt++;
                   if (m_cnt >= DF) begin emit = 1'b1; m_state = 2; end
               end else if (cls == 1) begin
                   m_cand = k; m_cnt = 1;
               end else m_state = 0;
            2: if (cls == 0) begin m_cnt = 1; m_state = (m_cnt >= DF) ? 0 : 3; end
            3: if (cls == 0) begin m_cnt++; if (m_cnt >= DF) m_state = 0; end else m_state = 2;
            default: m_state = 0;
        endcase
        m_held = (m_state == 2 || m_state == 3);
    endtask

    // One 12-cycle scan frame with keys m; entered just after a frame-end edge.
    task automatic run_frame(input logic [15:0] m);
        bit emit, held_before;
        logic [3:0] one, exp_col;
        int want;
        keys = m;
        held_before = m_held;
        model_frame(m, emit);
`ifndef KEYPAD_LEVEL_OUT_EN
        if (emit) exp_q.push_back(m_cand);
`endif
        one = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            exp_col = ~(one << (((i + 1) / 3) % 4));
            total++;
            if (keypadCol !== exp_col) begin
                bad++;
                $display("FAIL col_scan: keypadCol=%b want %b (sample %0d)", keypadCol, exp_col, i);
            end
`ifdef KEYPAD_LEVEL_OUT_EN
            begin
                logic exp_v;
                logic [3:0] exp_b;
                exp_v = (i == 11) ? m_held : held_before;
                exp_b = exp_v ? 4'(m_cand) : 4'd15;
                total++;
                if (keyValid !== exp_v || keyPadBuf !== exp_b) begin
                    bad++;
                    $display("FAIL level_out: valid=%b buf=%0d want valid=%b buf=%0d", keyValid, keyPadBuf, exp_v, exp_b);
                end
            end
`else
            total++;
            if (keyValid === 1'b1 && i == 11 && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (keyPadBuf !== 4'(want)) begin
                    bad++;
                    $display("FAIL key_code: keyPadBuf=%0d want %0d", keyPadBuf, want);
                end
            end else if (keyValid !== 1'b0 || keyPadBuf !== 4'd15) begin
                bad++;
                $display("FAIL idle_outputs: valid=%b buf=%0d want valid=0 buf=15 (sample %0d, held_before=%0b)", keyValid, keyPadBuf, i, held_before);
            end
`endif
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missed_pulse: %0d expected code(s) not seen, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        for (int f = 0; f < n; f++) run_frame(m);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (keypadCol !== 4'b1110 || keyPadBuf !== 4'd15 || keyValid !== 1'b0) begin
            bad++;
            $display("FAIL %s: col=%b buf=%0d valid=%b want col=1110 buf=15 valid=0", tag, keypadCol, keyPadBuf, keyValid);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        keys = 16'd0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        release_reset();
    endtask

    task automatic test_idle();
        frames(16'd0, 5);
    endtask

    task automatic test_single_press();
        frames(kb(1, 1), 4);
        frames(16'd0, 2);
    endtask

    task automatic test_short_and_bounce();
        frames(kb(2, 2), 1);
        frames(16'd0, 2);
        frames(kb(2, 2), 3);
        frames(16'd0, 1);
        frames(kb(2, 2), 3);
        frames(16'd0, 2);
    endtask

    task automatic test_multi_key();
        frames(kb(0, 0) | kb(0, 1), 4);
        frames(kb(0, 1), 2);
        frames(16'd0, 2);
        frames(kb(3, 3), 4);
        frames(16'd0, 2);
    endtask

    task automatic test_reset_mid_debounce();
        frames(kb(0, 2), 1);
        keys = kb(0, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (keyValid !== 1'b0) begin
                bad++;
                $display("FAIL mid_frame_valid: keyValid=%b want 0", keyValid);
            end
        end
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk); #1;
        check_reset_values("reset_hold");
        release_reset();
        frames(kb(0, 2), 2);
        frames(16'd0, 2);
    endtask

    task automatic test_back_to_back();
        frames(kb(0, 0), 2);
        frames(kb(2, 1), 3);
        frames(16'd0, 2);
        frames(kb(2, 1), 2);
        frames(16'd0, 2);
        frames(kb(1, 0), 5);
        frames(16'd0, 3);
    endtask

    task automatic test_code_map();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                frames(kb(r, c), 2);
                frames(16'd0, 2);
            end
        frames(kb(0, 3), 3);
        frames(16'd0, 2);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single_press();
        test_short_and_bounce();
        test_multi_key();
        test_reset_mid_debounce();
        test_back_to_back();
        test_code_map();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 membrane keypad and produces the board-position code consumed as `keyPadBuf` by the move-input logic. Drives one column low at a time, samples the active-low rows through a synchronizer, debounces whole scan frames, and emits a single-cycle code per debounced press. It sits between the board pins and the turn/timer logic, on the same 100 Hz `clk`.

## Interface
- `SCAN_DWELL`, 3: cycles each column is driven; minimum 3, covering the 2-flop synchronizer plus settle.
- `DEBOUNCE_FRAMES`, 2: consecutive identical frames required to accept a press or a release; minimum 1.
- `clk`  in  1  system clock (100 Hz).
- `rst`  in  1  asynchronous, active-high reset.
- `keypadRow`  in  4  row lines, active-low, pulled up externally.
- `keypadCol`  out  4  column drive, one-hot-low (exactly one bit 0 at all times).
- `keyPadBuf`  out  4  key code 0..8 while `keyValid`=1; otherwise 4'd15 (KEY_NONE).
- `keyValid`  out  1  high for one cycle per accepted press (level when configured).

## Operation
- Key map (row r, column c): (0,0..2)→0,1,2; (1,0..2)→3,4,5; (2,0..2)→6,7,8. Row 3 and column 3 keys are "non-board" keys: they count as pressed for frame classification, but never emit a code.
- Column scan: `colIdx` 0→1→2→3→0; each column is held `SCAN_DWELL` cycles; `keypadCol` = ~(1<<colIdx).
- Sampling: rows pass through a 2-flop synchronizer, reset value 4'hF. The synchronized rows are captured into the frame accumulator in the last dwell cycle of each column.
- Frame classification at the end of the column-3 dwell:
  - NONE: no key down.
  - SINGLE(code): exactly one key down, and it is a board key.
  - OTHER: more than one key down, or a single non-board key.
- Debounce FSM:
  - IDLE: SINGLE(k) → PRESS_CHK with cand=k, cnt=1. NONE or OTHER → stay.
  - PRESS_CHK:
    - SINGLE(cand) → cnt+1.
    - SINGLE(j≠cand) → cand=j, cnt=1.
    - NONE or OTHER → IDLE.
    - When cnt reaches `DEBOUNCE_FRAMES`: emit the code and go to HELD.
  - HELD: SINGLE or OTHER → stay. NONE → REL_CHK, cnt=1.
  - REL_CHK: NONE → cnt+1; reaching `DEBOUNCE_FRAMES` → IDLE. Any key down → HELD.
- With `DEBOUNCE_FRAMES`=1, PRESS_CHK is traversed in zero frames: the code is emitted at the first SINGLE frame.
- No second emission until a full debounced release has occurred.
- Counters saturate and never wrap. The frame counter width is $clog2(DEBOUNCE_FRAMES+1).

## Timing
- Frame length is 4·`SCAN_DWELL` cycles; 12 cycles by default.
- Press latency: `keyValid`/`keyPadBuf` are registered and assert the cycle after the frame end that completes the `DEBOUNCE_FRAMES`-th matching frame. `keyValid` is high for exactly one cycle; `keyPadBuf` returns to 4'd15 on the next cycle.
- Reset values: `keypadCol`=4'b1110, `keyPadBuf`=4'd15, `keyValid`=0, FSM=IDLE, `colIdx`=0, dwell/frame counters=0, accumulator cleared.
- Reset asserted mid-frame or mid-debounce discards all progress. After release, scanning restarts at column 0.
- A press shorter than `DEBOUNCE_FRAMES` frames produces no output.

## Configuration
- `KEYPAD_LEVEL_OUT_EN` undefined: pulse mode as above.
- `KEYPAD_LEVEL_OUT_EN` defined:
  - `keyValid`/`keyPadBuf` assert at the same cycle and stay asserted while in HELD or REL_CHK.
  - They drop to 0/4'd15 the cycle after the FSM returns to IDLE.
  - Used for hold-to-preview display.

## Structure
- `keypad_pkg` holds:
  - `KEY_NONE`=4'd15.
  - The FSM state typedef (IDLE, PRESS_CHK, HELD, REL_CHK).
  - The frame-class typedef (NONE, SINGLE, OTHER).
  - The row/column→code mapping function.
- One sub-module, `keypad_debounce`: the frame-level FSM plus counters. Inputs are the frame strobe, frame class, and code; outputs are emit and held.
- The top module keeps the column scan, synchronizer, and accumulator.

## Test plan
- Reset then idle rows 4'hF for 5 frames → `keypadCol` cycles 1110,1101,1011,0111 every 3 cycles; `keyValid` never asserts; `keyPadBuf`=15.
- Key (1,1) held 4 frames → exactly one `keyValid` pulse with `keyPadBuf`=4, 1 cycle after frame 2 ends; no repeat while held.
- Key (2,2) held 1 frame, then released → no output. Held 3 frames, bounced to NONE for 1 frame, held 3 more → exactly one pulse, code 8.
- Keys (0,0)+(0,1) together for 4 frames → no output. Releasing to (0,1) alone from IDLE → one pulse, code 1.
- Non-board key (3,3) for 4 frames → no output. Reset asserted during PRESS_CHK of key (0,2) → outputs return to reset values immediately; no pulse until a fresh 2-frame press.
- With `KEYPAD_LEVEL_OUT_EN`, key (1,0) held 5 frames → `keyPadBuf`=3 continuously from emission until 2 frames after release, then 15.
